aes_key_schedule: RTL
=====================

# aes_key_schedule

Iterative AES key-expansion engine that produces the full round-key array for AES-128, AES-192 or AES-256, selected per run by a `key_len` input. It generates one 32-bit schedule word per clock with four shared S-box instances, and holds the expanded words in an internal array. It is the next generation of the fixed AES-128 `keyexpansion` block. It feeds the cipher round datapath, and its `out` layout in AES-128 mode is bit-compatible with that block.

## Interface
- `MAX_KEY_BITS`, default 256: widest supported key (128, 192 or 256). It sets `NW_MAX` = 44/52/60 words.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: request expansion; sampled only when idle.
- `key_len` in 2: 00 = 128, 01 = 192, 10 = 256, 11 = illegal.
- `key` in `MAX_KEY_BITS`: cipher key, left-aligned. Key byte 0 is at the MSB; unused low bits are ignored.
- `busy` out 1: expansion in progress.
- `finish` out 1: level; the schedule is valid.
- `err` out 1: one-cycle pulse for a rejected start.
- `nr` out 4: round count of the last accepted key (10/12/14).
- `out` out `32*NW_MAX`: word i is at `out[32*NW_MAX-1-32*i -: 32]`. Word 0 is at the MSB.

## Operation
- States are IDLE, RUN and DONE. DONE behaves as IDLE for `start`.
- **Accepted start:** `start`=1 in IDLE or DONE with a legal `key_len`.
  - `key_len` must be ≤ `MAX_KEY_BITS`.
  - Set Nk = 4/6/8 and NW = 44/52/60.
  - Load words 0..Nk-1 from `key` and zero all other words.
  - Set the counter i = Nk, phase = 0 and rcon = 0x01. Then go to RUN, with `busy`=1 and `finish`=0.
- **Rejected start:** `start`=1 with `key_len`=11 or with a length above `MAX_KEY_BITS`.
  - Pulse `err` for one cycle.
  - State, `out`, `finish` and `nr` are unchanged.
- **`start` during RUN:** ignored, with no `err`. The run continues.
- **RUN computes one word per cycle.** With temp = w[i-1]:
  - If phase == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}.
  - Else if Nk == 8 and phase == 4: temp = SubWord(temp).
  - Then w[i] = w[i-Nk] ^ temp.
- **Counter and Rcon update:**
  - i increments each cycle. phase wraps at Nk-1 back to 0.
  - rcon advances by GF(2^8) xtime after each phase-0 word: 0x80 → 0x1b → 0x36.
- **Leaving RUN:** when i == NW-1 is written, go to DONE with `busy`=0 and `finish`=1.
- **Holding values:**
  - `finish` stays high until the next accepted start or reset.
  - `out` holds its value until the next accepted start.
  - `key` and `key_len` may change freely after the start edge.
- `nr` updates at the accepted-start edge.

## Timing
- **Reset values:** state IDLE; `busy`=0, `finish`=0, `err`=0, `nr`=0, `out`=0; counters 0, rcon 0x01.
- **Reset mid-RUN** aborts immediately to these reset values.
- **Latency:**
  - Edge E0 accepts `start`.
  - Edges E1..E(NW-Nk) write words Nk..NW-1.
  - `finish` rises and `busy` falls at edge E(NW-Nk): 40, 46 or 52 cycles for the three key lengths.
- **Back-to-back runs:** a `start` held high in DONE is accepted on the next edge. `finish` drops at that edge.
- **Single-cycle path:** one RotWord/SubWord/XOR per cycle. No array read other than w[i-1] and w[i-Nk].

## Structure
- **Package `aes_pkg`** holds:
  - the `key_len` encodings;
  - the Nk/NW/Nr constants per length;
  - the `xtime` function;
  - the 256-entry S-box constant.
- **Sub-module `aes_sbox`:** combinational 8-bit S-box, instantiated four times for SubWord. The cipher datapath reuses it.
- **Top level:** the FSM, the counters, the rcon register and the NW_MAX×32 word array.

## Test plan
- **FIPS-197 A.1:**
  - Stimulus: key 2b7e1516 28aed2a6 abf71588 09cf4f3c, `key_len`=00.
  - Required: w4 = a0fafe17, w43 = b6630ca6, `finish` at E40, `nr`=10, words 44..59 = 0.
- **FIPS-197 A.2:**
  - Stimulus: key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b, `key_len`=01.
  - Required: w51 = 01002202, `finish` at E46, `nr`=12.
- **FIPS-197 A.3:**
  - Stimulus: key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4, `key_len`=10.
  - Required: w59 = 706c631e, `finish` at E52, `nr`=14.
- **Reset mid-run:**
  - Stimulus: start the A.3 run, then assert `rst` at E20.
  - Required: all outputs are 0 immediately. A following A.1 run matches the A.1 results.
- **Illegal and ignored starts:**
  - `key_len`=11 → `err` pulses once and the DONE contents are unchanged.
  - With `MAX_KEY_BITS`=128, `key_len`=10 → `err` pulses once.
  - `start` pulses during RUN → no effect.
- **Back-to-back runs:**
  - Stimulus: `start` held high through A.1 completion with `key_len` switched to 01.
  - Required: the second run is accepted at E41, `finish` low for 46 cycles, and the result matches A.2.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants: key-length encodings, per-length schedule sizes, xtime and the S-box.
package aes_pkg;

   typedef enum logic [1:0] {
      KeyLen128 = 2'b00,
      KeyLen192 = 2'b01,
      KeyLen256 = 2'b10,
      KeyLenBad = 2'b11
   } key_len_e;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   localparam int unsigned Nk128 = 4;
   localparam int unsigned Nk192 = 6;
   localparam int unsigned Nk256 = 8;
   localparam int unsigned Nw128 = 44;
   localparam int unsigned Nw192 = 52;
   localparam int unsigned Nw256 = 60;
   localparam int unsigned Nr128 = 10;
   localparam int unsigned Nr192 = 12;
   localparam int unsigned Nr256 = 14;

   // Word-array depth needed for the widest key a build supports.
   function automatic int unsigned nw_for_bits(input int unsigned bits);
      if (bits >= 256) return Nw256;
      if (bits >= 192) return Nw192;
      return Nw128;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Entry 0 sits in the top byte.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
      logic [10:0] base;
      base = 11'd2047 - {x, 3'b000};
      return SBOX[base -: 8];
   endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Start/key request and expanded-schedule result bundle for the AES key schedule.
interface aes_key_schedule_if
   import aes_pkg::*;
#(
   parameter int unsigned MAX_KEY_BITS = 256
);
   localparam int unsigned NW_MAX = nw_for_bits(MAX_KEY_BITS);

   logic                     start;
   logic [1:0]               key_len;
   logic [MAX_KEY_BITS-1:0]  key;
   logic                     busy;
   logic                     finish;
   logic                     err;
   logic [3:0]               nr;
   logic [32*NW_MAX-1:0]     out;

   modport master (
      output start, key_len, key,
      input  busy, finish, err, nr, out
   );

   modport slave (
      input  start, key_len, key,
      output busy, finish, err, nr, out
   );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, shared with the cipher round datapath.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] data_i,
   output logic [7:0] data_o
);

   assign data_o = sbox_lookup(data_i);

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key expansion: one schedule word per clock into an internal array.
module aes_key_schedule
   import aes_pkg::*;
#(
   parameter int unsigned MAX_KEY_BITS = 256
) (
   input logic               clk,
   input logic               rst,
   aes_key_schedule_if.slave bus
);

   localparam int unsigned NwMax    = nw_for_bits(MAX_KEY_BITS);
   localparam int unsigned IdxW     = $clog2(NwMax + 1);
   localparam int unsigned KeyWords = MAX_KEY_BITS / 32;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   cnt_q, cnt_d;
   logic [IdxW-1:0]   phase_q, phase_d;
   logic [IdxW-1:0]   nk_q, nk_d;
   logic [IdxW-1:0]   nw_q, nw_d;
   logic [7:0]        rcon_q, rcon_d;
   logic [3:0]        nr_q, nr_d;
   logic              err_q, err_d;
   logic [31:0]       w_q [NwMax];
   logic [31:0]       w_d [NwMax];

   int unsigned       sel_nk, sel_nw, sel_nr, sel_bits;
   logic              len_ok;

   logic [31:0]       prev_w, old_w, rot_w, sub_in, sub_out, temp_w;
   logic [32*NwMax-1:0] out_flat;

   always_comb begin
      sel_nk   = Nk128;
      sel_nw   = Nw128;
      sel_nr   = Nr128;
      sel_bits = 128;
      len_ok   = 1'b1;
      case (key_len_e'(bus.key_len))
         KeyLen128: begin
            sel_nk = Nk128; sel_nw = Nw128; sel_nr = Nr128; sel_bits = 128;
         end
         KeyLen192: begin
            sel_nk = Nk192; sel_nw = Nw192; sel_nr = Nr192; sel_bits = 192;
         end
         KeyLen256: begin
            sel_nk = Nk256; sel_nw = Nw256; sel_nr = Nr256; sel_bits = 256;
         end
         default: len_ok = 1'b0;
      endcase
      if (sel_bits > MAX_KEY_BITS) len_ok = 1'b0;
   end

   // Only w[i-1] and w[i-Nk] are read from the array.
   assign prev_w = w_q[cnt_q - 1'b1];
   assign old_w  = w_q[cnt_q - nk_q];
   assign rot_w  = {prev_w[23:0], prev_w[31:24]};
   assign sub_in = (phase_q == '0) ? rot_w : prev_w;

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .data_i (sub_in[8*b +: 8]),
         .data_o (sub_out[8*b +: 8])
      );
   end

   always_comb begin
      temp_w = prev_w;
      if (phase_q == '0) begin
         temp_w = sub_out ^ {rcon_q, 24'h0};
      end else if (nk_q == IdxW'(Nk256) && phase_q == IdxW'(4)) begin
         temp_w = sub_out;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      nk_d    = nk_q;
      nw_d    = nw_q;
      rcon_d  = rcon_q;
      nr_d    = nr_q;
      err_d   = 1'b0;
      w_d     = w_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               if (len_ok) begin
                  for (int j = 0; j < NwMax; j++) w_d[j] = '0;
                  for (int j = 0; j < KeyWords; j++) begin
                     if (j < sel_nk) w_d[j] = bus.key[MAX_KEY_BITS-1-32*j -: 32];
                  end
                  nk_d    = IdxW'(sel_nk);
                  nw_d    = IdxW'(sel_nw);
                  nr_d    = 4'(sel_nr);
                  cnt_d   = IdxW'(sel_nk);
                  phase_d = '0;
                  rcon_d  = 8'h01;
                  state_d = StRun;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StRun: begin
            w_d[cnt_q] = old_w ^ temp_w;
            cnt_d      = cnt_q + 1'b1;
            phase_d    = (phase_q == nk_q - 1'b1) ? '0 : phase_q + 1'b1;
            if (phase_q == '0) rcon_d = xtime(rcon_q);
            if (cnt_q == nw_q - 1'b1) state_d = StDone;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         phase_q <= '0;
         nk_q    <= '0;
         nw_q    <= '0;
         rcon_q  <= 8'h01;
         nr_q    <= '0;
         err_q   <= 1'b0;
         for (int j = 0; j < NwMax; j++) w_q[j] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         nk_q    <= nk_d;
         nw_q    <= nw_d;
         rcon_q  <= rcon_d;
         nr_q    <= nr_d;
         err_q   <= err_d;
         w_q     <= w_d;
      end
   end

   always_comb begin
      out_flat = '0;
      for (int j = 0; j < NwMax; j++) out_flat[32*NwMax-1-32*j -: 32] = w_q[j];
   end

   assign bus.out    = out_flat;
   assign bus.busy   = (state_q == StRun);
   assign bus.finish = (state_q == StDone);
   assign bus.err    = err_q;
   assign bus.nr     = nr_q;

endmodule
